// File: rtl/ifmap_window_sequencer.sv
// rtl/ifmap_window_sequencer.sv - walks (stride_step, i) over every filter window, gated by buffer fill level
module ifmap_window_sequencer #(
    parameter int FILTER_SIZE_WIDTH = 4,
    parameter int I_WIDTH           = 4,
    parameter int STRIDE_WIDTH      = 4,
    parameter int COUNT_WIDTH       = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start_i,
    input  logic [I_WIDTH-1:0]           filter_size_i,
    input  logic [FILTER_SIZE_WIDTH-1:0] num_windows_i,
    input  logic [STRIDE_WIDTH-1:0]      stride_i,
    input  logic [COUNT_WIDTH-1:0]       if_count_i,
    input  logic                         ready_i,
    output logic                         valid_o,
    output logic [FILTER_SIZE_WIDTH-1:0] stride_step_o,
    output logic [I_WIDTH-1:0]           i_o,
    output logic                         last_in_window_o,
    output logic                         release_o,
    output logic                         busy_o,
    output logic                         done_o
);
    localparam int PROD_W = FILTER_SIZE_WIDTH + STRIDE_WIDTH + 1;
    localparam int OFF_W  = (COUNT_WIDTH > PROD_W) ? COUNT_WIDTH : PROD_W;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    state_e                         state_q, state_d;
    logic [FILTER_SIZE_WIDTH-1:0]   stride_step_q, stride_step_d;
    logic [I_WIDTH-1:0]             i_q, i_d;
    logic [I_WIDTH-1:0]             filter_size_q, filter_size_d;
    logic [FILTER_SIZE_WIDTH-1:0]   num_windows_q, num_windows_d;
    logic [STRIDE_WIDTH-1:0]        stride_q, stride_d;

    logic [OFF_W-1:0] step_ext, stride_ext, i_ext, count_ext, offset;
    logic             last_elem, last_window, avail;

    // Offset is measured from the current IF start, so it compares directly against the fill level.
    assign step_ext    = OFF_W'(stride_step_q);
    assign stride_ext  = OFF_W'(stride_q);
    assign i_ext       = OFF_W'(i_q);
    assign count_ext   = OFF_W'(if_count_i);
    assign offset      = step_ext * stride_ext + i_ext;
    assign avail       = offset < count_ext;
    assign last_elem   = (i_q == filter_size_q - I_WIDTH'(1));
    assign last_window = (stride_step_q == num_windows_q - FILTER_SIZE_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            stride_step_q <= '0;
            i_q           <= '0;
            filter_size_q <= '0;
            num_windows_q <= '0;
            stride_q      <= '0;
        end else begin
            state_q       <= state_d;
            stride_step_q <= stride_step_d;
            i_q           <= i_d;
            filter_size_q <= filter_size_d;
            num_windows_q <= num_windows_d;
            stride_q      <= stride_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        stride_step_d    = stride_step_q;
        i_d              = i_q;
        filter_size_d    = filter_size_q;
        num_windows_d    = num_windows_q;
        stride_d         = stride_q;
        valid_o          = 1'b0;
        last_in_window_o = 1'b0;
        release_o        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    filter_size_d = filter_size_i;
                    num_windows_d = num_windows_i;
                    stride_d      = stride_i;
                    stride_step_d = '0;
                    i_d           = '0;
                    state_d       = (filter_size_i == '0 || num_windows_i == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                valid_o          = avail;
                last_in_window_o = avail && last_elem;
                if (avail && ready_i) begin
                    if (!last_elem) begin
                        i_d = i_q + I_WIDTH'(1);
                    end else if (last_window) begin
                        // Final window is flushed by the buffer at pass end, so no release.
                        state_d = ST_DONE;
                    end else begin
                        i_d           = '0;
                        stride_step_d = stride_step_q + FILTER_SIZE_WIDTH'(1);
                        release_o     = 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign stride_step_o = stride_step_q;
    assign i_o           = i_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
endmodule

// File: tb/tb_ifmap_window_sequencer.sv
// tb/tb_ifmap_window_sequencer.sv - randomized bench against a window-list reference model
module tb_ifmap_window_sequencer;
    localparam int FSW = 4;
    localparam int IW  = 4;
    localparam int SW  = 4;
    localparam int CW  = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           start_i = 1'b0;
    logic [IW-1:0]  filter_size_i = '0;
    logic [FSW-1:0] num_windows_i = '0;
    logic [SW-1:0]  stride_i = '0;
    logic [CW-1:0]  if_count_i = '0;
    logic           ready_i = 1'b0;
    logic           valid_o, last_in_window_o, release_o, busy_o, done_o;
    logic [FSW-1:0] stride_step_o;
    logic [IW-1:0]  i_o;

    int checks = 0;
    int failures = 0;

    ifmap_window_sequencer #(
        .FILTER_SIZE_WIDTH(FSW), .I_WIDTH(IW), .STRIDE_WIDTH(SW), .COUNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .filter_size_i(filter_size_i), .num_windows_i(num_windows_i), .stride_i(stride_i),
        .if_count_i(if_count_i), .ready_i(ready_i), .valid_o(valid_o),
        .stride_step_o(stride_step_o), .i_o(i_o), .last_in_window_o(last_in_window_o),
        .release_o(release_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 32'(valid_o), 0);
        check_eq({tag, "_last"}, 32'(last_in_window_o), 0);
        check_eq({tag, "_release"}, 32'(release_o), 0);
        check_eq({tag, "_busy"}, 32'(busy_o), 0);
        check_eq({tag, "_done"}, 32'(done_o), 0);
    endtask

    // mode: 0 full buffer/ready high, 1 fill ramp, 2 ready toggling, 3 random ready and fill
    task automatic run_pass(input int fs, input int nw, input int st, input int mode,
                            input int full_cnt, input int abort_at, input bit inj_start);
        int qw[$];
        int qe[$];
        int k, cyc, off, cnt;
        bit ev;
        for (int w = 0; w < nw; w++)
            for (int e = 0; e < fs; e++) begin
                qw.push_back(w);
                qe.push_back(e);
            end
        @(posedge clk); #2;
        start_i       = 1'b1;
        filter_size_i = IW'(fs);
        num_windows_i = FSW'(nw);
        stride_i      = SW'(st);
        if_count_i    = (mode == 0) ? CW'(full_cnt) : '0;
        ready_i       = 1'b1;
        @(posedge clk); #2;
        start_i = 1'b0;
        if (fs == 0 || nw == 0) begin
            @(negedge clk);
            check_eq("empty_done", 32'(done_o), 1);
            check_eq("empty_busy", 32'(busy_o), 1);
            check_eq("empty_valid", 32'(valid_o), 0);
            @(posedge clk); #2;
            @(negedge clk);
            check_eq("empty_done_once", 32'(done_o), 0);
            check_eq("empty_idle_busy", 32'(busy_o), 0);
            return;
        end
        k = 0;
        cyc = 0;
        while (k < qw.size() && cyc < 3000) begin
            case (mode)
                0: begin ready_i = 1'b1; cnt = full_cnt; end
                1: begin ready_i = 1'b1; cnt = (cyc / 2 < full_cnt) ? cyc / 2 : full_cnt; end
                2: begin ready_i = (cyc % 2 == 0); cnt = full_cnt; end
                default: begin
                    ready_i = ($urandom_range(0, 3) != 0);
                    cnt = $urandom_range(0, full_cnt + 1);
                end
            endcase
            if (cnt > 255) cnt = 255;
            if_count_i = CW'(cnt);
            if (inj_start) begin
                start_i       = 1'($urandom_range(0, 1));
                filter_size_i = IW'($urandom_range(0, 15));
                num_windows_i = FSW'($urandom_range(0, 15));
                stride_i      = SW'($urandom_range(0, 15));
            end
            if (k == abort_at) begin
                #1 rst_n = 1'b0;
                #1;
                check_all_zero("abort");
                check_eq("abort_step", 32'(stride_step_o), 0);
                check_eq("abort_i", 32'(i_o), 0);
                @(posedge clk); #2;
                rst_n = 1'b1;
                start_i = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_eq("abort_no_done", 32'(done_o), 0);
                    check_eq("abort_no_busy", 32'(busy_o), 0);
                end
                return;
            end
            @(negedge clk);
            off = qw[k] * st + qe[k];
            ev  = off < cnt;
            check_eq("valid", 32'(valid_o), 32'(ev));
            check_eq("busy_run", 32'(busy_o), 1);
            check_eq("done_run", 32'(done_o), 0);
            if (ev) begin
                check_eq("stride_step", 32'(stride_step_o), 32'(qw[k]));
                check_eq("i", 32'(i_o), 32'(qe[k]));
                check_eq("last", 32'(last_in_window_o), 32'(qe[k] == fs - 1));
                check_eq("release", 32'(release_o),
                         32'((qe[k] == fs - 1) && ready_i && (qw[k] != nw - 1)));
            end else begin
                check_eq("last_idle", 32'(last_in_window_o), 0);
                check_eq("release_idle", 32'(release_o), 0);
            end
            if (ev && ready_i) k++;
            cyc++;
            @(posedge clk); #2;
        end
        start_i = 1'b0;
        check_eq("pass_complete", 32'(k), 32'(qw.size()));
        @(negedge clk);
        check_eq("done_pulse", 32'(done_o), 1);
        check_eq("done_busy", 32'(busy_o), 1);
        check_eq("done_valid", 32'(valid_o), 0);
        @(posedge clk); #2;
        @(negedge clk);
        check_eq("done_once", 32'(done_o), 0);
        check_eq("idle_busy", 32'(busy_o), 0);
    endtask

    initial begin
        int fs, nw, st;
        #12;
        check_all_zero("reset");
        check_eq("reset_step", 32'(stride_step_o), 0);
        check_eq("reset_i", 32'(i_o), 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("idle");

        run_pass(3, 4, 2, 0, 12, -1, 1'b0);
        run_pass(3, 4, 2, 1, 12, -1, 1'b0);
        run_pass(3, 4, 2, 2, 12, -1, 1'b0);
        run_pass(3, 0, 2, 0, 12, -1, 1'b0);
        run_pass(0, 3, 2, 0, 12, -1, 1'b0);
        run_pass(3, 4, 2, 0, 12, -1, 1'b1);
        run_pass(3, 4, 2, 0, 12, 7, 1'b0);
        run_pass(3, 4, 2, 0, 12, -1, 1'b0);
        repeat (10) begin
            fs = $urandom_range(1, 6);
            nw = $urandom_range(1, 6);
            st = $urandom_range(0, 5);
            run_pass(fs, nw, st, $urandom_range(0, 3), (nw - 1) * st + fs, -1,
                     1'($urandom_range(0, 1)));
        end
        run_pass(15, 15, 15, 0, 255, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ifmap_window_sequencer.md
# ifmap_window_sequencer

Generates the `(stride_step, i)` index stream that drives the IFMap read address generator. It walks every filter window over the IFMap circular buffer: element `i` of window `stride_step` for all windows of a convolution pass. A new index is offered only when the element it points to has already been written into the buffer. It uses a valid/ready handshake toward the PE datapath and tells the buffer's write side when window slots may be reclaimed.

## Interface
- `FILTER_SIZE_WIDTH`, 4: width of `stride_step` and `num_windows`.
- `I_WIDTH`, 4: width of `i` and `filter_size`.
- `STRIDE_WIDTH`, 4: width of `stride`.
- `COUNT_WIDTH`, 8: width of `if_count`; offsets compare at `max(COUNT_WIDTH, FILTER_SIZE_WIDTH+STRIDE_WIDTH+1)` bits.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  starts a pass; sampled only in IDLE.
- `filter_size`  in  I_WIDTH  elements per window; captured at start.
- `num_windows`  in  FILTER_SIZE_WIDTH  windows per pass; captured at start.
- `stride`  in  STRIDE_WIDTH  elements between window starts; captured at start.
- `if_count`  in  COUNT_WIDTH  valid elements currently held in the buffer, counted from the current IF start.
- `ready`  in  1  consumer accepts the current index.
- `valid`  out  1  `stride_step` and `i` are meaningful.
- `stride_step`  out  FILTER_SIZE_WIDTH  current window index.
- `i`  out  I_WIDTH  element index inside the window.
- `last_in_window`  out  1  `i == filter_size_r-1` while valid.
- `release`  out  1  one-cycle pulse: `stride_r` leading elements may be freed.
- `busy`  out  1  state is RUN or DONE.
- `done`  out  1  one-cycle pulse at end of pass.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On `start`, capture `filter_size_r`, `num_windows_r`, `stride_r` and clear both counters.
  - Go to RUN, or go to DONE if either captured size is 0.
- RUN:
  - `offset = stride_step*stride_r + i`, zero-extended.
  - `valid = (offset < if_count)`, combinational from the registers and the live `if_count`.
  - A handshake is `valid && ready`. On a handshake:
    - If not last in window, `i++`.
    - Else `i <= 0` and `stride_step++`.
    - If last in window and `stride_step == num_windows_r-1`, go to DONE instead.
- `release = valid && ready && last_in_window && !(stride_step == num_windows_r-1)`. The final window does not release; the buffer flushes it at pass end.
- DONE: `done` = 1 for exactly one cycle, then IDLE. Counters hold their last values.
- `start` in RUN or DONE is ignored. No queuing.
- `valid` may drop while `ready` is low, if `if_count` decreases. The consumer must not rely on `valid` staying high.
- Counters never wrap within a pass. Buffer wrap-around is handled downstream by the modulo in address generation.

## Timing
- Reset (async, `rst_n` = 0): state IDLE, `stride_step` = 0, `i` = 0, captured registers = 0.
  - All outputs 0: `valid`, `last_in_window`, `release`, `busy`, `done`.
  - Reset mid-pass aborts immediately, with no `done` pulse.
- `start` at edge N: RUN from N+1. The first `valid` is seen in cycle N+1 if `if_count > 0`.
- With `ready` held high and data available, there is one index per cycle.
- A pass takes `filter_size*num_windows` handshake cycles, plus 1 IDLE→RUN cycle and 1 DONE cycle.
- `release`, `valid` and `last_in_window` are combinational in the handshake cycle. `done` and `busy` are registered from state.
- `if_count` changing in the same cycle as a handshake: `valid` uses the current value. There is no stall beyond the comparison.

## Test plan
- filter_size=3, num_windows=4, stride=2, if_count=12, ready=1:
  - Pairs are (0,0),(0,1),(0,2),(1,0)…(3,2): 12 valid cycles.
  - `release` pulses after windows 0, 1, 2.
  - `done` comes 1 cycle after (3,2); `busy` stays high through that cycle.
- Same config with if_count ramping 0→12, +1 every 2 cycles:
  - `valid` is asserted only when offset < if_count.
  - Window 1 element 0 (offset 2) waits until if_count ≥ 3.
- ready toggled 1010…:
  - Indices advance only on handshake cycles; outputs hold stable while ready=0.
- num_windows=0 at start:
  - IDLE→DONE→IDLE, `done` pulses once, `valid` never asserts.
- Start asserted during RUN: ignored, and the index sequence is unchanged.
- Assert `rst_n`=0 for one cycle mid-pass at (2,1):
  - All outputs 0 immediately, no `done`.
  - A new `start` begins again at (0,0).
